// File: rtl/drrip_duel_ctrl.sv
// rtl/drrip_duel_ctrl.sv - DRRIP RRPV table with set-dueling insertion policy select
//
// Holds DEPTH x ASSOCIATIVITY RRPVs and serves one set per cycle to the per-set
// DRRIP policy block with one cycle of latency. Leader sets steer a saturating
// PSEL counter. Follower sets take SRRIP or BRRIP insertion from PSEL's MSB.
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   rd_req, rd_index         read request for one set
//   rd_valid                 registered response valid (one cycle after rd_req)
//   rd_entry[ASSOCIATIVITY]  RRPVs of the read set
//   rd_rrpv                  insertion RRPV chosen for the read set
//   rd_sel                   policy of the read set (0 = SRRIP, 1 = BRRIP)
//   wr_en, wr_index          whole-set write-back
//   wr_entry[ASSOCIATIVITY]  updated RRPVs for the written set
//   acc_done, acc_index,     completed-lookup report that drives PSEL
//   acc_miss
//   psel                     current policy-select counter
//
// Optional feature, macro DRRIP_DUEL_STATS_EN: adds the 32-bit outputs
// stat_srrip_miss, stat_brrip_miss and stat_flip.

module drrip_duel_ctrl #(
    parameter int ASSOCIATIVITY     = 4,
    parameter int DEPTH             = 64,
    parameter int INDEX_WIDTH       = 6,
    parameter int M                 = 2,
    parameter int PSEL_WIDTH        = 10,
    parameter int LEADER_STRIDE     = 32,
    parameter int BRRIP_COUNTER_LEN = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   rd_req,
    input  logic [INDEX_WIDTH-1:0] rd_index,
    output logic                   rd_valid,
    output logic [M-1:0]           rd_entry [ASSOCIATIVITY],
    output logic [M-1:0]           rd_rrpv,
    output logic                   rd_sel,
    input  logic                   wr_en,
    input  logic [INDEX_WIDTH-1:0] wr_index,
    input  logic [M-1:0]           wr_entry [ASSOCIATIVITY],
    input  logic                   acc_done,
    input  logic [INDEX_WIDTH-1:0] acc_index,
    input  logic                   acc_miss,
`ifdef DRRIP_DUEL_STATS_EN
    output logic [31:0]            stat_srrip_miss,
    output logic [31:0]            stat_brrip_miss,
    output logic [31:0]            stat_flip,
`endif
    output logic [PSEL_WIDTH-1:0]  psel
);

    localparam int LSW = $clog2(LEADER_STRIDE);
    localparam logic [M-1:0] DISTANT = {M{1'b1}};
    localparam logic [M-1:0] LONG    = DISTANT - M'(1);
    localparam logic [PSEL_WIDTH-1:0] PSEL_MAX  = {PSEL_WIDTH{1'b1}};
    localparam logic [PSEL_WIDTH-1:0] PSEL_INIT = {1'b1, {(PSEL_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        CLS_SRRIP  = 2'd0,
        CLS_BRRIP  = 2'd1,
        CLS_FOLLOW = 2'd2
    } set_class_e;

    // Leader class depends only on the index modulo the (power-of-two) stride.
    function automatic set_class_e set_class(input logic [INDEX_WIDTH-1:0] idx);
        logic [LSW-1:0] low;
        low = LSW'(idx);
        if (low == LSW'(0))      return CLS_SRRIP;
        else if (low == LSW'(1)) return CLS_BRRIP;
        else                     return CLS_FOLLOW;
    endfunction

    logic [M-1:0]                 table_q [DEPTH][ASSOCIATIVITY];
    logic [M-1:0]                 table_d [DEPTH][ASSOCIATIVITY];
    logic                         rd_valid_q, rd_valid_d;
    logic [M-1:0]                 rd_entry_q [ASSOCIATIVITY];
    logic [M-1:0]                 rd_entry_d [ASSOCIATIVITY];
    logic [M-1:0]                 rd_rrpv_q, rd_rrpv_d;
    logic                         rd_sel_q, rd_sel_d;
    logic [BRRIP_COUNTER_LEN-1:0] thr_q, thr_d;
    logic [PSEL_WIDTH-1:0]        psel_q, psel_d;

    set_class_e rd_cls;
    set_class_e acc_cls;
    logic       rd_sel_now;

    always_comb begin
        rd_cls  = set_class(rd_index);
        acc_cls = set_class(acc_index);
        case (rd_cls)
            CLS_SRRIP: rd_sel_now = 1'b0;
            CLS_BRRIP: rd_sel_now = 1'b1;
            default:   rd_sel_now = psel_q[PSEL_WIDTH-1];
        endcase
    end

    // Table write-back.
    always_comb begin
        table_d = table_q;
        if (wr_en) begin
            table_d[wr_index] = wr_entry;
        end
    end

    // Read path: a same-cycle write to the read index is forwarded. The read
    // sees the pre-update PSEL and the pre-increment BRRIP throttle.
    always_comb begin
        rd_valid_d = rd_req;
        rd_entry_d = rd_entry_q;
        rd_sel_d   = rd_sel_q;
        rd_rrpv_d  = rd_rrpv_q;
        thr_d      = thr_q;
        if (rd_req) begin
            if (wr_en && (wr_index == rd_index)) begin
                rd_entry_d = wr_entry;
            end else begin
                rd_entry_d = table_q[rd_index];
            end
            rd_sel_d = rd_sel_now;
            if (rd_sel_now) begin
                rd_rrpv_d = (thr_q == '0) ? LONG : DISTANT;
                thr_d     = thr_q + BRRIP_COUNTER_LEN'(1);
            end else begin
                rd_rrpv_d = LONG;
            end
        end
    end

    // PSEL: misses in SRRIP leaders push towards BRRIP, and the reverse.
    always_comb begin
        psel_d = psel_q;
        if (acc_done && acc_miss) begin
            if (acc_cls == CLS_SRRIP && psel_q != PSEL_MAX) begin
                psel_d = psel_q + PSEL_WIDTH'(1);
            end else if (acc_cls == CLS_BRRIP && psel_q != '0) begin
                psel_d = psel_q - PSEL_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < DEPTH; s++) begin
                for (int w = 0; w < ASSOCIATIVITY; w++) begin
                    table_q[s][w] <= DISTANT;
                end
            end
            for (int w = 0; w < ASSOCIATIVITY; w++) begin
                rd_entry_q[w] <= DISTANT;
            end
            rd_valid_q <= 1'b0;
            rd_rrpv_q  <= LONG;
            rd_sel_q   <= 1'b0;
            thr_q      <= '0;
            psel_q     <= PSEL_INIT;
        end else begin
            table_q    <= table_d;
            rd_entry_q <= rd_entry_d;
            rd_valid_q <= rd_valid_d;
            rd_rrpv_q  <= rd_rrpv_d;
            rd_sel_q   <= rd_sel_d;
            thr_q      <= thr_d;
            psel_q     <= psel_d;
        end
    end

    assign rd_valid = rd_valid_q;
    assign rd_entry = rd_entry_q;
    assign rd_rrpv  = rd_rrpv_q;
    assign rd_sel   = rd_sel_q;
    assign psel     = psel_q;

`ifdef DRRIP_DUEL_STATS_EN
    logic [31:0] srrip_miss_q, srrip_miss_d;
    logic [31:0] brrip_miss_q, brrip_miss_d;
    logic [31:0] flip_q, flip_d;

    always_comb begin
        srrip_miss_d = srrip_miss_q;
        brrip_miss_d = brrip_miss_q;
        flip_d       = flip_q;
        if (acc_done && acc_miss) begin
            if (acc_cls == CLS_SRRIP && srrip_miss_q != '1) begin
                srrip_miss_d = srrip_miss_q + 32'd1;
            end
            if (acc_cls == CLS_BRRIP && brrip_miss_q != '1) begin
                brrip_miss_d = brrip_miss_q + 32'd1;
            end
        end
        // A flip is a cycle whose PSEL update changes the policy MSB.
        if ((psel_d[PSEL_WIDTH-1] != psel_q[PSEL_WIDTH-1]) && flip_q != '1) begin
            flip_d = flip_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            srrip_miss_q <= '0;
            brrip_miss_q <= '0;
            flip_q       <= '0;
        end else begin
            srrip_miss_q <= srrip_miss_d;
            brrip_miss_q <= brrip_miss_d;
            flip_q       <= flip_d;
        end
    end

    assign stat_srrip_miss = srrip_miss_q;
    assign stat_brrip_miss = brrip_miss_q;
    assign stat_flip       = flip_q;
`endif

endmodule

// File: tb/tb_drrip_duel_ctrl.sv
// tb/tb_drrip_duel_ctrl.sv - scoreboard bench for drrip_duel_ctrl

module tb_drrip_duel_ctrl;

    logic       clk;
    logic       rst_n;
    logic       rd_req;
    logic [5:0] rd_index;
    logic       rd_valid;
    logic [1:0] rd_entry [4];
    logic [1:0] rd_rrpv;
    logic       rd_sel;
    logic       wr_en;
    logic [5:0] wr_index;
    logic [1:0] wr_entry [4];
    logic       acc_done;
    logic [5:0] acc_index;
    logic       acc_miss;
    logic [9:0] psel;
`ifdef DRRIP_DUEL_STATS_EN
    logic [31:0] stat_srrip_miss, stat_brrip_miss, stat_flip;
`endif

    drrip_duel_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .rd_req(rd_req), .rd_index(rd_index),
        .rd_valid(rd_valid), .rd_entry(rd_entry), .rd_rrpv(rd_rrpv), .rd_sel(rd_sel),
        .wr_en(wr_en), .wr_index(wr_index), .wr_entry(wr_entry),
        .acc_done(acc_done), .acc_index(acc_index), .acc_miss(acc_miss),
`ifdef DRRIP_DUEL_STATS_EN
        .stat_srrip_miss(stat_srrip_miss), .stat_brrip_miss(stat_brrip_miss),
        .stat_flip(stat_flip),
`endif
        .psel(psel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Reference model: plain integers and arrays.
    int m_tbl [64][4];
    int m_psel;
    int m_thr;
    typedef struct {
        int e [4];
        int sel;
        int rrpv;
    } resp_t;
    resp_t exp_q [$];

    task automatic model_reset();
        for (int s = 0; s < 64; s++)
            for (int w = 0; w < 4; w++) m_tbl[s][w] = 3;
        m_psel = 512;
        m_thr  = 0;
        exp_q.delete();
    endtask

    function automatic int cls_of(input int idx);
        return idx % 32;
    endfunction

    always @(negedge rst_n) model_reset();

    always @(posedge clk) begin
        if (!rst_n) begin
            model_reset();
        end else begin
            if (rd_req) begin
                resp_t r;
                int c;
                c = cls_of(int'(rd_index));
                if (c == 0)      r.sel = 0;
                else if (c == 1) r.sel = 1;
                else             r.sel = (m_psel >= 512) ? 1 : 0;
                r.rrpv = (r.sel == 1 && m_thr != 0) ? 3 : 2;
                for (int w = 0; w < 4; w++)
                    r.e[w] = (wr_en && wr_index == rd_index) ? int'(wr_entry[w])
                                                              : m_tbl[rd_index][w];
                if (r.sel == 1) m_thr = (m_thr + 1) % 32;
                exp_q.push_back(r);
            end
            if (wr_en)
                for (int w = 0; w < 4; w++) m_tbl[wr_index][w] = int'(wr_entry[w]);
            if (acc_done && acc_miss) begin
                if (cls_of(int'(acc_index)) == 0 && m_psel < 1023) m_psel++;
                else if (cls_of(int'(acc_index)) == 1 && m_psel > 0) m_psel--;
            end
        end
    end

    // Monitor: compares every response the DUT presents against the queue head.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_rd_valid", rd_valid, 0);
            chk("rst_psel", psel, 512);
            chk("rst_rd_rrpv", rd_rrpv, 2);
            chk("rst_rd_sel", rd_sel, 0);
        end else begin
            chk("psel", psel, m_psel);
            if (rd_valid) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_rd_valid", rd_valid, 0);
                end else begin
                    resp_t r;
                    r = exp_q.pop_front();
                    for (int w = 0; w < 4; w++) chk("rd_entry", rd_entry[w], r.e[w]);
                    chk("rd_sel", rd_sel, r.sel);
                    chk("rd_rrpv", rd_rrpv, r.rrpv);
                end
            end else if (exp_q.size() != 0) begin
                chk("missing_rd_valid", rd_valid, 1);
                exp_q.delete();
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rd_req   = 1'b0;
        wr_en    = 1'b0;
        acc_done = 1'b0;
        acc_miss = 1'b0;
    endtask

    task automatic set_wr(input int a, input int b, input int c, input int d);
        wr_entry[0] = 2'(a);
        wr_entry[1] = 2'(b);
        wr_entry[2] = 2'(c);
        wr_entry[3] = 2'(d);
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        rd_index = '0; wr_index = '0; acc_index = '0;
        set_wr(0, 0, 0, 0);
        idle();
        step();
        step();
        rst_n = 1'b1;
        chk("psel_after_reset", psel, 512);

        // Read from reset state.
        rd_req = 1'b1; rd_index = 6'd5; step();
        idle(); step();

        // Write then read, then same-cycle write/read bypass.
        wr_en = 1'b1; wr_index = 6'd7; set_wr(0, 1, 2, 3); step();
        idle(); rd_req = 1'b1; rd_index = 6'd7; step();
        idle(); wr_en = 1'b1; wr_index = 6'd9; set_wr(1, 1, 1, 1);
        rd_req = 1'b1; rd_index = 6'd9; step();
        idle(); step();

        // PSEL saturation both ways, then hits.
        acc_done = 1'b1; acc_miss = 1'b1; acc_index = 6'd0;
        repeat (600) step();
        idle(); step();
        chk("psel_sat_hi", psel, 1023);
        acc_done = 1'b1; acc_miss = 1'b1; acc_index = 6'd33;
        repeat (1100) step();
        idle(); step();
        chk("psel_sat_lo", psel, 0);
        acc_done = 1'b1; acc_miss = 1'b0; acc_index = 6'd0;
        repeat (10) step();
        idle(); step();
        chk("psel_hits", psel, 0);

        // Follower at psel = 0, then BRRIP leader throttle sequence.
        rd_req = 1'b1; rd_index = 6'd2;
        repeat (4) step();
        rd_index = 6'd1;
        repeat (33) step();
        idle(); step();

        // Reset with reads in flight.
        rd_req = 1'b1; rd_index = 6'd34; step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_rd_valid", rd_valid, 0);
        chk("rst_mid_psel", psel, 512);
        idle(); step(); step();
        rst_n = 1'b1;
        step();
        chk("rd_valid_after_release", rd_valid, 0);
        for (int s = 0; s < 64; s++) begin
            rd_req = 1'b1; rd_index = 6'(s); step();
        end
        idle(); step();

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            int pick;
            rd_req   = ($urandom_range(0, 9) < 7);
            rd_index = 6'($urandom_range(0, 63));
            wr_en    = ($urandom_range(0, 9) < 3);
            wr_index = ($urandom_range(0, 3) == 0) ? rd_index : 6'($urandom_range(0, 63));
            set_wr($urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 3), $urandom_range(0, 3));
            acc_done = ($urandom_range(0, 1) == 1);
            acc_miss = ($urandom_range(0, 3) != 0);
            pick = $urandom_range(0, 4);
            case (pick)
                0: acc_index = 6'd0;
                1: acc_index = 6'd33;
                2: acc_index = 6'd32;
                3: acc_index = 6'd1;
                default: acc_index = 6'($urandom_range(0, 63));
            endcase
            step();
        end
        idle(); step(); step();

`ifdef DRRIP_DUEL_STATS_EN
        do_reset();
        step();
        acc_done = 1'b1; acc_miss = 1'b1; acc_index = 6'd0;
        repeat (3) step();
        acc_index = 6'd1;
        repeat (2) step();
        idle(); step();
        chk("stat_srrip_miss", stat_srrip_miss, 3);
        chk("stat_brrip_miss", stat_brrip_miss, 2);
        chk("stat_flip", stat_flip, 0);
`else
        do_reset();
        step();
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
